// File: rtl/ip4_rtl_spa_wbq.sv
// SPA result writeback queue: in-order FIFO, push-to-wb_req latency 1 cycle, head shown combinationally.
// Backpressure: res_rdy drops when full, draining or flushing; the head is held until wb_gnt.
module ip4_rtl_spa_wbq #(
  parameter int WORD_W = 32,
  parameter int ADR_W  = 6,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     res_vld,
  output logic                     res_rdy,
  input  logic [ADR_W-1:0]         res_adr,
  input  logic [WORD_W-1:0]        res_dat,
  output logic                     wb_req,
  input  logic                     wb_gnt,
  output logic [ADR_W-1:0]         wb_adr,
  output logic [WORD_W-1:0]        wb_dat,
  input  logic                     flush,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t                     r_state;
  logic [PW-1:0]              r_wr_ptr;
  logic [PW-1:0]              r_rd_ptr;
  logic [CW-1:0]              r_cnt;
  logic                       r_drain_done;
  logic [ADR_W+WORD_W-1:0]    r_mem [DEPTH];

  logic w_push;
  logic w_pop;
  logic w_drain_exit;

  assign res_rdy    = (r_state == RUN) && (r_cnt < CW'(DEPTH)) && !flush;
  assign wb_req     = (r_cnt != '0) && !flush;
  assign {wb_adr, wb_dat} = r_mem[r_rd_ptr];
  assign cnt        = r_cnt;
  assign drain_done = r_drain_done;

  assign w_push = res_vld && res_rdy;
  assign w_pop  = wb_req && wb_gnt;

  // Leave DRAIN on the cycle whose edge empties the queue (or finds it already empty).
  assign w_drain_exit = (r_state == DRAIN) &&
                        (flush || (r_cnt == '0) || ((r_cnt == CW'(1)) && w_pop));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {res_adr, res_dat};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_drain_done <= 1'b0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + CW'(1);
          2'b01:   r_cnt <= r_cnt - CW'(1);
          default: r_cnt <= r_cnt;
        endcase
      end

      r_drain_done <= w_drain_exit;
      case (r_state)
        RUN:     if (drain_req) r_state <= DRAIN;
        DRAIN:   if (w_drain_exit) r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ip4_rtl_spa_wbq.sv
// Bench for ip4_rtl_spa_wbq: directed scenarios plus random traffic against a queue-based model.
module tb_ip4_rtl_spa_wbq;

  localparam int WW = 32;
  localparam int AW = 6;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          res_vld;
  logic          res_rdy;
  logic [AW-1:0] res_adr;
  logic [WW-1:0] res_dat;
  logic          wb_req;
  logic          wb_gnt;
  logic [AW-1:0] wb_adr;
  logic [WW-1:0] wb_dat;
  logic          flush;
  logic          drain_req;
  logic          drain_done;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  ip4_rtl_spa_wbq #(.WORD_W(WW), .ADR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_adr(res_adr), .res_dat(res_dat),
    .wb_req(wb_req), .wb_gnt(wb_gnt), .wb_adr(wb_adr), .wb_dat(wb_dat),
    .flush(flush), .drain_req(drain_req), .drain_done(drain_done), .cnt(cnt)
  );

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [WW-1:0] dat;
  } ent_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t sb[$];
  bit   m_drain = 1'b0;
  bit   m_done  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain queue of accepted results plus a draining flag, evaluated just before each edge.
  always @(negedge clk) begin
    bit   e_rdy, e_req, push, pop, exit_d;
    ent_t e;
    if (!rst_n) begin
      sb.delete();
      m_drain = 1'b0;
      m_done  = 1'b0;
    end else begin
      e_rdy = !m_drain && (sb.size() < D) && !flush;
      e_req = (sb.size() != 0) && !flush;
      chk("res_rdy", 64'(res_rdy), 64'(e_rdy));
      chk("wb_req", 64'(wb_req), 64'(e_req));
      chk("cnt", 64'(cnt), 64'(sb.size()));
      chk("drain_done", 64'(drain_done), 64'(m_done));
      if (e_req) begin
        chk("wb_adr", 64'(wb_adr), 64'(sb[0].adr));
        chk("wb_dat", 64'(wb_dat), 64'(sb[0].dat));
      end
      push = res_vld && e_rdy;
      pop  = e_req && wb_gnt;
      if (flush) begin
        sb.delete();
      end else begin
        if (pop) void'(sb.pop_front());
        if (push) begin
          e.adr = res_adr;
          e.dat = res_dat;
          sb.push_back(e);
        end
      end
      exit_d = m_drain && (sb.size() == 0);
      m_done = exit_d;
      if (m_drain) m_drain = !exit_d;
      else         m_drain = drain_req;
    end
  end

  task automatic cyc(input bit v, input logic [AW-1:0] a, input logic [WW-1:0] d,
                     input bit g, input bit f, input bit dr);
    @(posedge clk);
    #1;
    res_vld   = v;
    res_adr   = a;
    res_dat   = d;
    wb_gnt    = g;
    flush     = f;
    drain_req = dr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, 0, 0);
  endtask

  initial begin
    int pv, pg;
    rst_n = 1'b0; res_vld = 0; res_adr = '0; res_dat = '0;
    wb_gnt = 0; flush = 0; drain_req = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single push held until granted
    cyc(1, 6'd5, 32'h1111_1111, 0, 0, 0);
    idle(3);
    cyc(0, '0, '0, 1, 0, 0);
    idle(1);

    // Fill to full, then pop while the SPA keeps offering
    for (int i = 1; i <= 5; i++) cyc(1, AW'(i), WW'(i), 0, 0, 0);
    cyc(1, 6'd9, 32'h99, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, '0, '0, 1, 0, 0);

    // Steady push+pop at cnt=2 across pointer wrap
    cyc(1, 6'd20, 32'hA0, 0, 0, 0);
    cyc(1, 6'd21, 32'hA1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, AW'(22 + i), WW'(32'hB0 + i), 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, '0, 1, 0, 0);

    // Flush with a concurrent push at cnt=3
    for (int i = 0; i < 3; i++) cyc(1, AW'(40 + i), WW'(i), 0, 0, 0);
    cyc(1, 6'd50, 32'hDEAD, 1, 1, 0);
    idle(2);

    // Drain at cnt=2, then grant
    cyc(1, 6'd1, 32'hC1, 0, 0, 0);
    cyc(1, 6'd2, 32'hC2, 0, 0, 0);
    cyc(0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 6'd3, 32'hC3, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, '0, 1, 0, 0);

    // Drain on an empty queue
    cyc(0, '0, '0, 0, 0, 1);
    idle(3);

    // Random traffic in phases biasing toward full, empty and simultaneous push/pop
    for (int ph = 0; ph < 40; ph++) begin
      case (ph % 4)
        0:       begin pv = 90;  pg = 10;  end
        1:       begin pv = 50;  pg = 50;  end
        2:       begin pv = 100; pg = 100; end
        default: begin pv = 20;  pg = 90;  end
      endcase
      for (int i = 0; i < 50; i++)
        cyc($urandom_range(99) < pv, AW'($urandom), WW'($urandom),
            $urandom_range(99) < pg, $urandom_range(99) < 3, $urandom_range(99) < 5);
    end

    // Asynchronous reset in the middle of a drain with cnt=3
    cyc(0, '0, '0, 0, 1, 0);
    idle(2);
    for (int i = 0; i < 3; i++) cyc(1, AW'(60 + i), WW'(i), 0, 0, 0);
    cyc(0, '0, '0, 0, 0, 1);
    idle(1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("cnt_async_rst", 64'(cnt), 64'd0);
    chk("wb_req_async_rst", 64'(wb_req), 64'd0);
    chk("drain_done_async_rst", 64'(drain_done), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(0, '0, '0, 1, 0, 0);
      chk("drain_done_after_rst", 64'(drain_done), 64'd0);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ip4_rtl_spa_wbq.md
IP4_RTL_SPA_WBQ -- requirements
Module: ip4_rtl_spa_wbq

Interface
REQ-001 SHALL have parameter WORD_W, default 32, result data width.
REQ-002 SHALL have parameter ADR_W, default 6, destination register address width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port res_vld  input  1  SPA result valid.
REQ-007 SHALL have port res_rdy  output  1  queue accepts result this cycle.
REQ-008 SHALL have port res_adr  input  ADR_W  SPA result destination register.
REQ-009 SHALL have port res_dat  input  WORD_W  SPA result value.
REQ-010 SHALL have port wb_req  output  1  writeback request to register file.
REQ-011 SHALL have port wb_gnt  input  1  register file accepts head entry.
REQ-012 SHALL have port wb_adr  output  ADR_W  head entry address.
REQ-013 SHALL have port wb_dat  output  WORD_W  head entry data.
REQ-014 SHALL have port flush  input  1  discard all queued results.
REQ-015 SHALL have port drain_req  input  1  pulse, request barrier drain.
REQ-016 SHALL have port drain_done  output  1  one-cycle pulse, drain complete.
REQ-017 SHALL have port cnt  output  log2(DEPTH)+1  current occupancy.

Function
REQ-018 SHALL be a DEPTH-entry in-order FIFO with registered rd/wr pointers of log2(DEPTH) bits wrapping modulo DEPTH, and a counter cnt.
REQ-019 SHALL push {res_adr,res_dat} on a rising edge when res_vld && res_rdy.
REQ-020 SHALL drive res_rdy = (state==RUN) && (cnt<DEPTH) && !flush; no bypass when full, even if a pop occurs the same cycle.
REQ-021 SHALL drive wb_req = (cnt!=0) && !flush, with wb_adr/wb_dat taken combinationally from the head entry.
REQ-022 SHALL pop the head on a rising edge when wb_req && wb_gnt; pop latency from push to earliest wb_req = 1 cycle.
REQ-023 SHALL, on simultaneous push and pop, leave cnt unchanged and advance both pointers.
REQ-024 SHALL hold wb_adr/wb_dat stable while wb_req=1 and wb_gnt=0.
REQ-025 SHALL, when flush=1, set cnt=0 and both pointers=0 at the next edge; any push or pop in that cycle is ignored.
REQ-026 SHALL implement states RUN and DRAIN; RUN->DRAIN when drain_req=1.
REQ-027 SHALL, in DRAIN, hold res_rdy=0 and continue popping; DRAIN->RUN when cnt==0 (or next cycle cnt will be 0 via pop or flush), asserting drain_done for exactly that transition cycle's following cycle (registered pulse).
REQ-028 SHALL, if drain_req arrives with cnt==0 in RUN, enter DRAIN and pulse drain_done the next cycle, then return to RUN.
REQ-029 SHALL ignore drain_req while already in DRAIN.
REQ-030 SHALL never overflow or underflow cnt; res_vld while res_rdy=0 is held by the SPA, not lost.

Reset
REQ-031 SHALL, on rst_n=0 (asynchronous, any cycle including mid-drain), force state=RUN, cnt=0, pointers=0, drain_done=0; res_rdy=1 and wb_req=0 after reset release.
REQ-032 SHALL not require reset of storage array contents.

Verification
REQ-033 Reset, then push adr=5 dat=0x11111111, wb_gnt=0 -> wb_req=1 next cycle, wb_adr=5, wb_dat=0x11111111, held until gnt.
REQ-034 Push 4 entries, gnt=0 -> cnt=4, res_rdy=0; assert gnt with res_vld=1 same cycle -> cnt=3, no push; order of pops 1,2,3,4 preserved.
REQ-035 cnt=2, push and pop same cycle -> cnt stays 2, pointers wrap correctly after 8 such cycles.
REQ-036 cnt=3, flush=1 with res_vld=1 -> next cycle cnt=0, wb_req=0, pushed entry discarded.
REQ-037 cnt=2, drain_req pulse, gnt=1 -> res_rdy=0 for 2 cycles, drain_done high one cycle after last pop, then res_rdy=1.
REQ-038 rst_n low during DRAIN with cnt=3 -> immediately cnt=0, drain_done never asserts.
